// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared types and constants for the repeated-addition
//                multiplier (controller state encoding, default watchdog
//                limit, datapath width).
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  // Default iteration limit before the watchdog forces DONE with err.
  localparam int unsigned c_max_iter = 65535;
  // Default width of the controller's iteration counter.
  localparam int unsigned c_iter_w   = 16;
  // Width of operand A, counter B and accumulator P in the datapath.
  localparam int unsigned c_data_w   = 16;

  // Controller states; encodings are fixed so they can be decoded externally.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    CHK  = 3'd3,
    ADD  = 3'd4,
    DONE = 3'd5
  } mul_state_t;

endpackage
`default_nettype wire

// File: rtl/mul_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_ctrl_if
//  Description : Host/datapath handshake bundle for the multiplier
//                controller. master = host + datapath side, slave = mul_ctrl.
//                Optional macro MUL_CTRL_ABORT_EN adds the abort request.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_ctrl_if;

  // Requests from the host and the B==0 flag from the datapath.
  logic start;
  logic eqz;
  logic ack;
`ifdef MUL_CTRL_ABORT_EN
  logic abort;
`endif

  // Controller status and datapath strobes.
  logic ready;
  logic lda;
  logic ldb;
  logic decb;
  logic clrp;
  logic ldp;
  logic done;
  logic err;

  modport master (
    output start, eqz, ack,
`ifdef MUL_CTRL_ABORT_EN
    output abort,
`endif
    input  ready, lda, ldb, decb, clrp, ldp, done, err
  );

  modport slave (
    input  start, eqz, ack,
`ifdef MUL_CTRL_ABORT_EN
    input  abort,
`endif
    output ready, lda, ldb, decb, clrp, ldp, done, err
  );

endinterface
`default_nettype wire

// File: rtl/mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_ctrl
//  Description : Moore FSM sequencing the repeated-addition multiplier:
//                load A, load B, then one P<=P+A / B<=B-1 step per
//                iteration until B==0. start/done/ack host handshake plus
//                an iteration watchdog that ends the run with err set.
//                Optional macro MUL_CTRL_ABORT_EN: abort returns to IDLE
//                from any busy state without a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned MAX_ITER = c_max_iter,
  parameter int unsigned ITER_W   = c_iter_w
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  mul_ctrl_if.slave   bus
);

  // Watchdog limit expressed in the counter's own width.
  localparam logic [ITER_W-1:0] c_iter_max = ITER_W'(MAX_ITER);

  mul_state_t        r_state;
  mul_state_t        w_state_next;
  logic [ITER_W-1:0] r_iter;
  logic              r_err;
  logic              w_iter_max;
  logic              w_abort;

  assign w_iter_max = (r_iter == c_iter_max);

  // abort only matters once an operation is under way.
`ifdef MUL_CTRL_ABORT_EN
  assign w_abort = bus.abort && (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // State register; reset returns to IDLE without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state selection and Moore output decode from the current state.
  always_comb begin
    w_state_next = r_state;
    bus.ready    = 1'b0;
    bus.lda      = 1'b0;
    bus.ldb      = 1'b0;
    bus.decb     = 1'b0;
    bus.clrp     = 1'b0;
    bus.ldp      = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;

    case (r_state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          w_state_next = LDA;
        end
      end
      LDA: begin
        bus.lda      = 1'b1;
        bus.clrp     = 1'b1;
        w_state_next = LDB;
      end
      LDB: begin
        bus.ldb      = 1'b1;
        w_state_next = CHK;
      end
      CHK: begin
        // Zero multiplier and watchdog expiry both finish the run.
        if (bus.eqz || w_iter_max) begin
          w_state_next = DONE;
        end else begin
          w_state_next = ADD;
        end
      end
      ADD: begin
        bus.ldp      = 1'b1;
        bus.decb     = 1'b1;
        w_state_next = CHK;
      end
      DONE: begin
        bus.done = 1'b1;
        // err is only meaningful while the result is being presented.
        bus.err  = r_err;
        if (bus.ack) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // abort overrides every other transition.
    if (w_abort) begin
      w_state_next = IDLE;
    end
  end

  // Iteration counter and watchdog flag, both restarted on every LDA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iter <= '0;
      r_err  <= 1'b0;
    end else if (w_abort) begin
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        LDA: begin
          r_iter <= '0;
          r_err  <= 1'b0;
        end
        CHK: begin
          // Watchdog trips only when B is still non-zero at the limit.
          if (!bus.eqz && w_iter_max) begin
            r_err <= 1'b1;
          end
        end
        ADD: begin
          // Saturate rather than wrap; CHK normally exits first.
          if (!w_iter_max) begin
            r_iter <= r_iter + 1'b1;
          end
        end
        default: begin
          r_iter <= r_iter;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_ctrl
//  Description : Directed self-checking bench for mul_ctrl with a
//                behavioural A/B/P datapath around two controllers: one at
//                the default watchdog limit, one with MAX_ITER=3.
//                Abort checks are compiled when MUL_CTRL_ABORT_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mul_ctrl_if ifm ();
  mul_ctrl_if ifw ();

  mul_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifm)
  );

  mul_ctrl #(
    .MAX_ITER (3),
    .ITER_W   (16)
  ) u_dut_wd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifw)
  );

  // Host data bus: A while either controller strobes lda, otherwise B.
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [15:0] dbus;
  assign dbus = (ifm.lda || ifw.lda) ? op_a : op_b;

  // Datapath model for the default-limit controller.
  logic [15:0] a_m = '0, b_m = '0, p_m = '0;
  int          ldp_m = 0, decb_m = 0;
  always @(posedge clk) begin
    if (ifm.lda)  begin a_m <= dbus; ldp_m <= 0; decb_m <= 0; end
    if (ifm.ldb)  b_m <= dbus;
    if (ifm.decb) begin b_m <= b_m - 16'd1; decb_m <= decb_m + 1; end
    if (ifm.clrp) p_m <= '0;
    if (ifm.ldp)  begin p_m <= p_m + a_m; ldp_m <= ldp_m + 1; end
  end
  assign ifm.eqz = (b_m == 16'd0);

  // Datapath model for the watchdog controller.
  logic [15:0] a_w = '0, b_w = '0, p_w = '0;
  int          ldp_w = 0;
  always @(posedge clk) begin
    if (ifw.lda)  begin a_w <= dbus; ldp_w <= 0; end
    if (ifw.ldb)  b_w <= dbus;
    if (ifw.decb) b_w <= b_w - 16'd1;
    if (ifw.clrp) p_w <= '0;
    if (ifw.ldp)  begin p_w <= p_w + a_w; ldp_w <= ldp_w + 1; end
  end
  assign ifw.eqz = (b_w == 16'd0);

  // Strobe exclusivity: one of lda/ldb/ldp at most, decb only with ldp.
  int viol = 0;
  always @(negedge clk) begin
    if ((int'(ifm.lda) + int'(ifm.ldb) + int'(ifm.ldp)) > 1 || ifm.decb != ifm.ldp ||
        (int'(ifw.lda) + int'(ifw.ldb) + int'(ifw.ldp)) > 1 || ifw.decb != ifw.ldp)
      viol <= viol + 1;
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start on the main controller and count edges until done rises.
  // poke: assert start and ack while busy, which must be ignored.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit poke,
                        output int lat);
    op_a = a;
    op_b = b;
    ifm.start = 1'b1;
    @(posedge clk); #1;
    ifm.start = 1'b0;
    lat = 1;
    while (!ifm.done && lat < 400) begin
      if (poke && lat == 3) begin ifm.start = 1'b1; ifm.ack = 1'b1; end
      if (poke && lat == 6) begin ifm.start = 1'b0; ifm.ack = 1'b0; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack_op(input string tag);
    ifm.ack = 1'b1;
    @(posedge clk); #1;
    ifm.ack = 1'b0;
    check(tag, {ifm.ready, ifm.done}, 32'd2);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end, expected finish");
    $fatal(1);
  end

  int lat;
  int cnt;

  initial begin
    ifm.start = 1'b0; ifm.ack = 1'b0;
    ifw.start = 1'b0; ifw.ack = 1'b0;
`ifdef MUL_CTRL_ABORT_EN
    ifm.abort = 1'b0; ifw.abort = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ifm.ready, 32'd1);
    check("rst_outs", {ifm.lda, ifm.ldb, ifm.decb, ifm.clrp, ifm.ldp, ifm.done, ifm.err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 7 x 5: 2*5+4 = 14 edges.
    run_op(16'd7, 16'd5, 1'b0, lat);
    check("basic_lat", lat, 32'd14);
    check("basic_done", ifm.done, 32'd1);
    check("basic_p", p_m, 32'd35);
    check("basic_err", ifm.err, 32'd0);
    check("basic_ldp", ldp_m, 32'd5);
    check("basic_decb", decb_m, 32'd5);

    // done must hold without ack.
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ifm.done) cnt++;
    end
    check("done_hold", cnt, 32'd20);
    check("hold_p", p_m, 32'd35);

    // start and ack together: back to IDLE, no new LDA.
    ifm.start = 1'b1; ifm.ack = 1'b1;
    @(posedge clk); #1;
    ifm.start = 1'b0; ifm.ack = 1'b0;
    check("startack_idle", {ifm.ready, ifm.done}, 32'd2);
    @(posedge clk); #1;
    check("startack_nolda", {ifm.lda, ifm.ready}, 32'd1);

    // start/ack while busy are ignored: 3 x 4 runs normally in 12 edges.
    run_op(16'd3, 16'd4, 1'b1, lat);
    check("busy_lat", lat, 32'd12);
    check("busy_p", p_m, 32'd12);
    check("busy_ldp", ldp_m, 32'd4);
    ack_op("busy_ack");

    // Zero multiplier: 4 edges, no ADD.
    run_op(16'd9, 16'd0, 1'b0, lat);
    check("zero_lat", lat, 32'd4);
    check("zero_done", ifm.done, 32'd1);
    check("zero_p", p_m, 32'd0);
    check("zero_ldp", ldp_m, 32'd0);
    ack_op("zero_ack");

    // Watchdog at MAX_ITER=3: 4 x 10 stops after 3 ADDs, 10 edges.
    op_a = 16'd4; op_b = 16'd10;
    ifw.start = 1'b1;
    @(posedge clk); #1;
    ifw.start = 1'b0;
    lat = 1;
    while (!ifw.done && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check("wd_lat", lat, 32'd10);
    check("wd_err", ifw.err, 32'd1);
    check("wd_p", p_w, 32'd12);
    check("wd_ldp", ldp_w, 32'd3);
    ifw.ack = 1'b1;
    @(posedge clk); #1;
    ifw.ack = 1'b0;
    check("wd_ack", {ifw.ready, ifw.done, ifw.err}, 32'd4);

    // Asynchronous reset in the middle of ADD (3 x 9).
    op_a = 16'd3; op_b = 16'd9;
    ifm.start = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      ifm.start = 1'b0;
    end
    check("pre_rst_add", {ifm.ldp, ifm.decb}, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ready", ifm.ready, 32'd1);
    check("arst_outs", {ifm.lda, ifm.ldb, ifm.decb, ifm.clrp, ifm.ldp, ifm.done, ifm.err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'd6, 16'd2, 1'b0, lat);
    check("post_rst_lat", lat, 32'd8);
    check("post_rst_p", p_m, 32'd12);
    ack_op("post_rst_ack");

`ifdef MUL_CTRL_ABORT_EN
    // Abort during the second ADD of 2 x 6.
    op_a = 16'd2; op_b = 16'd6;
    ifm.start = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      ifm.start = 1'b0;
    end
    check("abort_in_add2", {ifm.ldp, 27'd0, ldp_m[3:0]}, 32'h8000_0001);
    ifm.abort = 1'b1;
    @(posedge clk); #1;
    ifm.abort = 1'b0;
    check("abort_idle", ifm.ready, 32'd1);
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ifm.done || ifm.err) cnt++;
    end
    check("abort_no_done", cnt, 32'd0);
`endif

    check("strobe_rules", viol, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
